mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64, number of 32-bit words stored.
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request acceptance to response; legal range 1..15.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset).
REQ-005 SHALL have port req  input  1  initiator request strobe.
REQ-006 SHALL have port we  input  1  1 = write, 0 = read; sampled with req.
REQ-007 SHALL have port adr  input  32  byte address; sampled with req.
REQ-008 SHALL have port wd  input  32  write data; sampled with req.
REQ-009 SHALL have port rd  output  32  read data; valid while ready=1.
REQ-010 SHALL have port ready  output  1  one-cycle completion pulse.
REQ-011 SHALL have port err  output  1  error flag, valid while ready=1.
REQ-012 SHALL have port busy  output  1  1 while a request is outstanding.

Function
REQ-013 SHALL implement states IDLE, WAIT, DONE.
REQ-014 SHALL accept a request only in IDLE with req=1, capturing we, adr, wd and moving to WAIT.
REQ-015 SHALL load a down-counter with LATENCY-1 on acceptance, decrement it in WAIT, and go to DONE when it reaches 0.
REQ-016 SHALL assert ready for exactly one cycle in DONE, LATENCY cycles after the acceptance edge, then return to IDLE.
REQ-017 SHALL ignore req while in WAIT or DONE; no queuing.
REQ-018 SHALL set busy=1 in WAIT and DONE, and busy=0 in IDLE.
REQ-019 SHALL flag a request as erroneous when adr[1:0] != 0 or adr[31:2] >= DEPTH_WORDS.
REQ-020 SHALL perform a legal write in the DONE cycle at word index adr[31:2], with rd=0 and err=0.
REQ-021 SHALL present, for a legal read, the stored word at adr[31:2] on rd in the DONE cycle, with err=0.
REQ-022 SHALL complete an erroneous request normally (ready pulse, err=1, rd=0) with no memory update.
REQ-023 SHALL hold rd=0 and err=0 whenever ready=0.
REQ-024 SHALL return a write in DONE immediately followed by a read to the same address with the newly written data.
REQ-025 SHALL use captured request fields only; adr, wd and we changes after acceptance have no effect.

Reset
REQ-026 SHALL, while reset=0 at a clock edge, force state to IDLE, clear the counter and captured fields, and drive ready=0, err=0, busy=0, rd=0.
REQ-027 SHALL abort an outstanding request if reset occurs mid-operation: no write commits and no ready pulse follows.
REQ-028 SHALL leave memory contents unchanged by reset (contents are not reset).
REQ-029 SHALL ignore a req held high during reset; the first acceptance occurs in the first IDLE cycle after reset=1.

Structure
REQ-030 SHALL take the state enum (IDLE/WAIT/DONE) and constant WORD_BYTES=4 from shared package mem_pkg.
REQ-031 SHALL instantiate word storage as sub-module mem_ram: one synchronous write port and one read port, with the read registered so data lands in the DONE cycle.
REQ-032 SHALL keep LATENCY counter width at 4 bits.

Verification
REQ-033 SHALL cover: reset=0 for 2 cycles, then req=1 we=1 adr=84 wd=7 -> busy=1, ready pulse exactly 2 cycles later with err=0.
REQ-034 SHALL cover: after REQ-033, req=1 we=0 adr=84 -> ready pulse 2 cycles later with rd=7, err=0.
REQ-035 SHALL cover: req=1 we=1 adr=82 wd=5 -> ready with err=1; a later read of adr=80 returns its prior value, unchanged.
REQ-036 SHALL cover: req=1 we=0 adr=256 (DEPTH_WORDS=64) -> ready with err=1, rd=0.
REQ-037 SHALL cover: req held high continuously -> requests accepted only from IDLE, with ready spaced LATENCY+1 cycles apart.
REQ-038 SHALL cover: write of adr=80 wd=9 with reset=0 asserted in the WAIT cycle -> no ready pulse; a subsequent read of adr=80 returns its old value.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the word-addressed memory responder.
// Imported by the responder top and its storage sub-module.
package mem_pkg;

    localparam int DATA_W     = 32;
    localparam int WORD_BYTES = 4;
    localparam int OFS_W      = $clog2(WORD_BYTES);
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    typedef struct packed {
        logic              we;
        logic [31:0]       adr;
        logic [DATA_W-1:0] wd;
    } req_t;

    // Misaligned or beyond the last stored word.
    function automatic logic addr_err(
        input logic [31:0] adr,
        input int unsigned depth
    );
        logic [31:0] idx;
        idx = adr >> OFS_W;
        return (adr[OFS_W-1:0] != '0) || (idx >= depth);
    endfunction

endpackage

// File: rtl/mem_ram.sv
// Word storage: one synchronous write port, one registered read port.
// Contents are never reset.
module mem_ram
    import mem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic              clk,
    input  logic              wen,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with fixed request-to-response
// latency, alignment/range error reporting and a one-cycle ready pulse.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [31:0]       adr,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd,
    output logic              ready,
    output logic              err,
    output logic              busy
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    req_t              cap;
    logic              bad;
    logic              rd_sel;
    logic              wen;
    logic [AW-1:0]     idx;
    logic [DATA_W-1:0] ram_q;

    assign bad = addr_err(cap.adr, DEPTH_WORDS);
    assign idx = cap.adr[AW+OFS_W-1:OFS_W];

    // Commit only on a clean DONE edge so a reset there aborts the write.
    assign wen = (state == DONE) && cap.we && !bad && reset;

    assign rd = rd_sel ? ram_q : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            cap    <= '0;
            ready  <= 1'b0;
            err    <= 1'b0;
            busy   <= 1'b0;
            rd_sel <= 1'b0;
        end else begin
            ready  <= 1'b0;
            err    <= 1'b0;
            rd_sel <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req) begin
                        cap.we  <= we;
                        cap.adr <= adr;
                        cap.wd  <= wd;
                        cnt     <= CNT_W'(LATENCY - 1);
                        busy    <= 1'b1;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state  <= DONE;
                        ready  <= 1'b1;
                        err    <= bad;
                        rd_sel <= !cap.we && !bad;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    mem_ram #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .wen   (wen),
        .waddr (idx),
        .wdata (cap.wd),
        .raddr (idx),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Directed, table-driven bench for mem_responder (DEPTH_WORDS=64,
// LATENCY=2) plus hand sequences for back-to-back and reset-abort cases.
module tb_mem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        ready;
    logic        err;
    logic        busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wd;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    mem_responder #(
        .DEPTH_WORDS (64),
        .LATENCY     (LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .we    (we),
        .adr   (adr),
        .wd    (wd),
        .rd    (rd),
        .ready (ready),
        .err   (err),
        .busy  (busy)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE, scramble inputs after acceptance,
    // then time the ready pulse and check the response.
    task automatic do_req(input vec_t v, input string name);
        int n;
        req = 1'b1;
        we  = v.we;
        adr = v.adr;
        wd  = v.wd;
        tick();
        req = 1'b0;
        we  = ~v.we;
        adr = v.adr ^ 32'h0000_0004;
        wd  = ~v.wd;
        chk({name, " busy"}, 32'(busy), 32'd1);
        chk({name, " early"}, 32'(ready), 32'd0);
        n = 0;
        while (!ready && n < 20) begin
            tick();
            n++;
        end
        chk({name, " latency"}, n, LAT);
        chk({name, " err"}, 32'(err), 32'(v.exp_err));
        chk({name, " rd"}, rd, v.exp_rd);
        tick();
        chk({name, " post ready"}, 32'(ready), 32'd0);
        chk({name, " post busy"}, 32'(busy), 32'd0);
        chk({name, " post rd"}, rd, 32'd0);
        chk({name, " post err"}, 32'(err), 32'd0);
    endtask

    initial begin
        int t;
        int last;
        int pulses;
        vec_t v;

        vecs[0] = '{1'b1, 32'd84,  32'd7,        1'b0, 32'd0};
        vecs[1] = '{1'b0, 32'd84,  32'd0,        1'b0, 32'd7};
        vecs[2] = '{1'b1, 32'd80,  32'h11,       1'b0, 32'd0};
        vecs[3] = '{1'b1, 32'd82,  32'd5,        1'b1, 32'd0};
        vecs[4] = '{1'b0, 32'd80,  32'd0,        1'b0, 32'h11};
        vecs[5] = '{1'b0, 32'd256, 32'd0,        1'b1, 32'd0};
        vecs[6] = '{1'b1, 32'd252, 32'hA5A5_5A5A, 1'b0, 32'd0};
        vecs[7] = '{1'b0, 32'd252, 32'd0,        1'b0, 32'hA5A5_5A5A};
        vecs[8] = '{1'b1, 32'd256, 32'hDEAD,     1'b1, 32'd0};
        vecs[9] = '{1'b0, 32'd1,   32'd0,        1'b1, 32'd0};

        // Reset with a request held high; nothing may be accepted.
        reset = 1'b0;
        req   = 1'b1;
        we    = 1'b1;
        adr   = 32'd84;
        wd    = 32'd7;
        tick();
        tick();
        chk("rst ready", 32'(ready), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst err", 32'(err), 32'd0);
        chk("rst rd", rd, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            do_req(vecs[i], $sformatf("vec%0d", i));
        end

        // Continuous req: pulses every LAT+2 edges (LAT+1 idle cycles).
        req    = 1'b1;
        we     = 1'b0;
        adr    = 32'd84;
        wd     = 32'd0;
        last   = 0;
        pulses = 0;
        for (t = 1; t <= 16; t++) begin
            tick();
            if (ready) begin
                pulses++;
                chk("cont rd", rd, 32'd7);
                if (pulses == 1) begin
                    chk("cont first", t, LAT + 1);
                end else begin
                    chk("cont gap", t - last, LAT + 2);
                end
                last = t;
            end
        end
        chk("cont pulses", pulses, 4);
        req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("cont idle busy", 32'(busy), 32'd0);

        // Reset during WAIT aborts the write to 80.
        req = 1'b1;
        we  = 1'b1;
        adr = 32'd80;
        wd  = 32'd9;
        tick();
        req = 1'b0;
        chk("abort busy", 32'(busy), 32'd1);
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("abort busy0", 32'(busy), 32'd0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ready) pulses++;
        end
        chk("abort no ready", pulses, 0);
        v = '{1'b0, 32'd80, 32'd0, 1'b0, 32'h11};
        do_req(v, "abort read80");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
